// File: rtl/lotr_debounce_pkg.sv
// lotr_debounce_pkg: shared FSM state type and default parameters for the input debouncer
package lotr_debounce_pkg;
    typedef enum logic [1:0] {STABLE_LO, ARM_HI, STABLE_HI, ARM_LO} t_db_state;
    localparam int DB_DEF_STABLE_CYCLES = 25000;
    localparam logic [11:0] DB_DEF_INV_MASK = 12'h003;
endpackage

// File: rtl/lotr_debounce_bit.sv
// lotr_debounce_bit: one-input synchroniser, stability FSM and optional pulse flops (LOTR_DEBOUNCE_PULSE_EN)
module lotr_debounce_bit
    import lotr_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DB_DEF_STABLE_CYCLES,
    parameter int CNT_W = $clog2(STABLE_CYCLES)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
`ifdef LOTR_DEBOUNCE_PULSE_EN
    ,
    output logic chg_o
`endif
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    t_db_state state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic sync1_q, sync2_q, level_q, level_d;
    // synchroniser, FSM state, qualification counter and registered level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end
    // a new level must persist for STABLE_CYCLES synchronised cycles; any reversal rearms
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        level_d = level_q;
        case (state_q)
            STABLE_LO: if (sync2_q) begin
                state_d = ARM_HI;
                cnt_d   = CNT_W'(1);
            end
            ARM_HI: if (!sync2_q) state_d = STABLE_LO;
                else if (cnt_q == LAST) begin
                    state_d = STABLE_HI;
                    level_d = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
            STABLE_HI: if (!sync2_q) begin
                state_d = ARM_LO;
                cnt_d   = CNT_W'(1);
            end
            ARM_LO: if (sync2_q) state_d = STABLE_HI;
                else if (cnt_q == LAST) begin
                    state_d = STABLE_LO;
                    level_d = 1'b0;
                end else cnt_d = cnt_q + 1'b1;
            default: state_d = STABLE_LO;
        endcase
    end
    assign level_o = level_q;
`ifdef LOTR_DEBOUNCE_PULSE_EN
    logic rise_q, fall_q;
    // edge pulses registered alongside the level so they land in its first new cycle
    always_ff @(posedge clk_i) begin
        rise_q <= rst_i ? 1'b0 : level_d & ~level_q;
        fall_q <= rst_i ? 1'b0 : ~level_d & level_q;
    end
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign chg_o  = level_d ^ level_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif
endmodule

// File: rtl/lotr_io_debounce.sv
// lotr_io_debounce: polarity-normalised debounced board inputs; pulses built only with LOTR_DEBOUNCE_PULSE_EN
module lotr_io_debounce
    import lotr_debounce_pkg::*;
#(
    parameter int NUM_IN = 12,
    parameter int STABLE_CYCLES = DB_DEF_STABLE_CYCLES,
    parameter logic [NUM_IN-1:0] INV_MASK = NUM_IN'(DB_DEF_INV_MASK),
    parameter int CNT_W = $clog2(STABLE_CYCLES)
) (
    input  logic              QClk,
    input  logic              RstQnnnH,
    input  logic [NUM_IN-1:0] RawIn,
    output logic [NUM_IN-1:0] DbLevel,
    output logic [NUM_IN-1:0] DbRise,
    output logic [NUM_IN-1:0] DbFall,
    output logic              DbAnyChange
);
    logic [NUM_IN-1:0] raw_n;
    assign raw_n = RawIn ^ INV_MASK;
`ifdef LOTR_DEBOUNCE_PULSE_EN
    logic [NUM_IN-1:0] chg;
    logic any_q;
    // summary change flag registered in the same cycle as the per-bit pulses
    always_ff @(posedge QClk) begin
        any_q <= RstQnnnH ? 1'b0 : |chg;
    end
    assign DbAnyChange = any_q;
`else
    assign DbAnyChange = 1'b0;
`endif
    for (genvar i = 0; i < NUM_IN; i++) begin : g_bit
        lotr_debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W(CNT_W)
        ) u_bit (
            .clk_i(QClk),
            .rst_i(RstQnnnH),
            .raw_i(raw_n[i]),
            .level_o(DbLevel[i]),
            .rise_o(DbRise[i]),
            .fall_o(DbFall[i])
`ifdef LOTR_DEBOUNCE_PULSE_EN
            ,
            .chg_o(chg[i])
`endif
        );
    end
endmodule

// File: tb/tb_lotr_io_debounce.sv
// tb_lotr_io_debounce: randomized scoreboard bench against a run-length debounce model
module tb_lotr_io_debounce;
    localparam int S = 4;
    localparam logic [11:0] M = 12'h003;
    logic QClk, RstQnnnH;
    logic [11:0] RawIn, DbLevel, DbRise, DbFall;
    logic DbAnyChange;
    int n_cmp = 0, n_bad = 0;
    typedef struct packed {logic [11:0] lvl, rise, fall; logic any;} exp_t;
    exp_t q[$];
    lotr_io_debounce #(.NUM_IN(12), .STABLE_CYCLES(S), .INV_MASK(M)) dut (
        .QClk(QClk), .RstQnnnH(RstQnnnH), .RawIn(RawIn),
        .DbLevel(DbLevel), .DbRise(DbRise), .DbFall(DbFall), .DbAnyChange(DbAnyChange)
    );
    initial begin
        QClk = 1'b0;
        forever #5 QClk = ~QClk;
    end
    task automatic chk(input string n, input logic [11:0] a, input logic [11:0] x);
        n_cmp++;
        if (a !== x) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h", n, $time, a, x);
        end
    endtask
    // reference: inputs reach the decision point two samples late; a level flips once the
    // delayed input has disagreed with it for S consecutive cycles
    initial begin
        logic [11:0] s1, s2, lvl;
        int run[12];
        exp_t e;
        s1 = '0; s2 = '0; lvl = '0;
        foreach (run[b]) run[b] = 0;
        forever begin
            @(posedge QClk);
            e = '0;
            if (RstQnnnH) begin
                s1 = '0; s2 = '0; lvl = '0;
                foreach (run[b]) run[b] = 0;
            end else begin
                for (int b = 0; b < 12; b++) begin
                    run[b] = (s2[b] != lvl[b]) ? run[b] + 1 : 0;
                    if (run[b] == S) begin
                        run[b] = 0;
                        lvl[b] = ~lvl[b];
                        if (lvl[b]) e.rise[b] = 1'b1;
                        else e.fall[b] = 1'b1;
                    end
                end
                s2 = s1;
                s1 = RawIn ^ M;
            end
            e.lvl = lvl;
`ifdef LOTR_DEBOUNCE_PULSE_EN
            e.any = |(e.rise | e.fall);
`else
            e.rise = '0;
            e.fall = '0;
            e.any = 1'b0;
`endif
            q.push_back(e);
        end
    end
    // monitor: outputs are presented every cycle; compare against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge QClk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("level", DbLevel, e.lvl);
                chk("rise", DbRise, e.rise);
                chk("fall", DbFall, e.fall);
                chk("any", {11'b0, DbAnyChange}, {11'b0, e.any});
            end
        end
    end
    task automatic cyc(input int n);
        repeat (n) @(negedge QClk);
    endtask
    initial begin
        int rate;
        RstQnnnH = 1'b1;
        RawIn = 12'h003;
        cyc(3);
        RstQnnnH = 1'b0;
        cyc(20);
        RawIn[0] = 1'b0;
        cyc(15);
        for (int t = 0; t < 20; t++) begin
            RawIn[4] = ~RawIn[4];
            cyc(2);
        end
        RawIn[4] = 1'b0;
        cyc(10);
        RawIn[11:2] = '1;
        cyc(15);
        RstQnnnH = 1'b1;
        cyc(1);
        RstQnnnH = 1'b0;
        cyc(15);
        RawIn[2] = 1'b0;
        RawIn[0] = 1'b1;
        cyc(15);
        for (int c = 0; c < 4000; c++) begin
            rate = ((c / 200) % 2 != 0) ? 15 : 3;
            for (int b = 0; b < 12; b++)
                if ($urandom_range(0, rate) == 0) RawIn[b] = ~RawIn[b];
            RstQnnnH = ($urandom_range(0, 599) == 0);
            cyc(1);
        end
        RstQnnnH = 1'b0;
        cyc(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
